move_request_sequencer: RTL

Initiator side of the sprite movement interface. It turns raw player buttons into one-hot move requests on a fixed move tick. It owns the sprite's current position and feeds it to the position updater. It commits the position the updater returns, and flags each request as a completed move or a blocked move (wall).

---
 rtl/move_request_sequencer_pkg.sv | 42 ++++
 rtl/move_request_sequencer_button_debouncer.sv | 45 ++++
 rtl/move_request_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/move_request_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// move_request_sequencer_pkg : shared directions, sprite ids, widths. rev 1.0
// ==========================================================================
package move_request_sequencer_pkg;

  localparam int X_W  = 11;
  localparam int Y_W  = 10;
  localparam int STEP = 15;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    PACMAN = 3'd0,
    BLINKY = 3'd1,
    PINKY  = 3'd2,
    INKY   = 3'd3,
    CLYDE  = 3'd4
  } sprite_id_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } seq_state_t;

  // Same-cycle press edges resolve RIGHT > LEFT > UP > DOWN.
  function automatic logic [3:0] press_priority(input logic [3:0] edges);
    if (edges[0])      return DIR_RIGHT;
    else if (edges[3]) return DIR_LEFT;
    else if (edges[1]) return DIR_UP;
    else if (edges[2]) return DIR_DOWN;
    return DIR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_request_sequencer_button_debouncer.sv
`default_nettype none
// ==========================================================================
// button_debouncer : 2-flop sync, stability counter, press-edge pulse. rev 1.0
// ==========================================================================
module button_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic press
);

  logic [1:0]  sync;
  logic        stable;
  logic [15:0] cnt;
  logic        accept;

  // Accept on the DEBOUNCE_CYCLES-th consecutive sample that differs from stable.
  assign accept = (sync[1] != stable) &&
                  (({1'b0, cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES});

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b00;
      stable <= 1'b0;
      cnt    <= 16'd0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_async};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= 16'd0;
      end else if (accept) begin
        stable <= sync[1];
        cnt    <= 16'd0;
        press  <= sync[1];
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_request_sequencer.sv
`default_nettype none
// ==========================================================================
// move_request_sequencer : buttons -> one-hot move requests, commits returned
// position and flags moved/blocked.                                 rev 1.0
// ==========================================================================
module move_request_sequencer
  import move_request_sequencer_pkg::*;
#(
  parameter logic [15:0]    DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0]    MOVE_PERIOD     = 24'd2500000,
  parameter int             RESP_LATENCY    = 1,
  parameter logic [2:0]     SPRITE_ID       = PACMAN,
  parameter logic [X_W-1:0] RESET_POS_X     = 11'd10,
  parameter logic [Y_W-1:0] RESET_POS_Y     = 10'd10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     btn_in,
  input  logic           game_run,
  input  logic [X_W-1:0] new_pos_x,
  input  logic [Y_W-1:0] new_pos_y,
  output logic [3:0]     move_direction,
  output logic [2:0]     which_sprite,
  output logic [X_W-1:0] curr_pos_x,
  output logic [Y_W-1:0] curr_pos_y,
  output logic [3:0]     heading,
  output logic           moved,
  output logic           blocked
);

  localparam logic [7:0] LAT_LAST = (RESP_LATENCY > 0) ? 8'(RESP_LATENCY - 1) : 8'd0;

  logic [3:0]  press;
  logic [3:0]  pending;
  logic [23:0] tick_cnt;
  logic        tick;
  seq_state_t  state, state_nx;
  logic [3:0]  dir, dir_nx;
  logic [7:0]  wait_cnt, wait_nx;
  logic        commit_move;
  logic        commit_block;
  logic        pos_changed;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk      (clk),
      .rst      (rst),
      .btn_async(btn_in[i]),
      .press    (press[i])
    );
  end

  assign tick = game_run && (tick_cnt == (MOVE_PERIOD - 24'd1));

  always_ff @(posedge clk) begin
    if (rst || !game_run || tick) tick_cnt <= 24'd0;
    else                          tick_cnt <= tick_cnt + 24'd1;
  end

  assign pos_changed = (new_pos_x != curr_pos_x) || (new_pos_y != curr_pos_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir      <= DIR_NONE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    dir_nx       = dir;
    wait_nx      = wait_cnt;
    commit_move  = 1'b0;
    commit_block = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          dir_nx = (pending != DIR_NONE) ? pending : heading;
          if (dir_nx != DIR_NONE) state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_nx  = 8'd0;
        state_nx = (RESP_LATENCY == 0) ? ST_COMMIT : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == LAT_LAST) state_nx = ST_COMMIT;
        else                      wait_nx  = wait_cnt + 8'd1;
      end
      ST_COMMIT: begin
        state_nx = ST_IDLE;
        if (pos_changed) begin
          commit_move = 1'b1;
        end else begin
          commit_block = 1'b1;
          // A blocked turn falls back to the current heading once; after the
          // retry dir equals heading, so a second retry cannot trigger.
          if (dir == pending && heading != DIR_NONE && heading != pending) begin
            dir_nx   = heading;
            state_nx = ST_ISSUE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curr_pos_x <= RESET_POS_X;
      curr_pos_y <= RESET_POS_Y;
      heading    <= DIR_NONE;
      pending    <= DIR_NONE;
      moved      <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      moved   <= commit_move;
      blocked <= commit_block;
      if (commit_move) begin
        curr_pos_x <= new_pos_x;
        curr_pos_y <= new_pos_y;
        heading    <= dir;
        if (dir == pending) pending <= DIR_NONE;
      end
      if (press != 4'b0000) pending <= press_priority(press);
    end
  end

  assign move_direction = (!rst && (state == ST_ISSUE || state == ST_WAIT)) ? dir : DIR_NONE;
  assign which_sprite   = SPRITE_ID;

endmodule
`default_nettype wire
